// File: rtl/handshake_rx.sv
// Receive side of a 4-phase req/ack crossing: synchronises req, captures the word,
// returns ack and presents the word through a one-entry valid/ready buffer.
module handshake_rx #(
  parameter int DATA_W      = 40,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              ack_o,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              rdy_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  xfer_cnt_o,
  output logic [1:0]        fsm_state_o
);

  // Handshake: a word moves to the consumer on any clk edge where vld_o & rdy_i.
  // vld_o never drops without that transfer, and data_o is stable while vld_o & !rdy_i.

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACK  = 2'b01
  } state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     req_s;
  logic                     ack_q;
  logic                     vld_q;
  logic [DATA_W-1:0]        data_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     drain;
  logic                     space;
  logic                     capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign drain = vld_q & rdy_i;
  assign space = !vld_q | drain;

  // State register; ack is its own flop so the sender sees a glitch-free level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
    end
  end

  always_comb begin
    state_d = IDLE;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && space) begin
          state_d = ACK;
          capture = 1'b1;
        end
      end
      ACK: begin
        state_d = req_s ? ACK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_o       = ack_q;
    vld_o       = vld_q;
    data_o      = data_q;
    xfer_cnt_o  = cnt_q;
    busy_o      = (state_q != IDLE) | vld_q;
    fsm_state_o = state_q;
  end

  // Output buffer: a capture wins over a drain in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (capture) begin
        vld_q  <= 1'b1;
        data_q <= req_data_i;
        cnt_q  <= cnt_q + CNT_W'(1);
      end else if (drain) begin
        vld_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_handshake_rx.sv
// Directed bench for handshake_rx: reset, latency, backpressure, ordered stream,
// counter wrap and three-stage synchroniser latency.
module tb_handshake_rx;

  logic        clk;
  logic        rst;
  logic        req;
  logic [39:0] req_data;
  logic        ack;
  logic        vld;
  logic [39:0] data;
  logic        rdy;
  logic        busy;
  logic [15:0] cnt;
  logic [1:0]  st;

  logic        w_req;
  logic [39:0] w_data_in;
  logic        w_ack;
  logic        w_vld;
  logic [39:0] w_data;
  logic        w_rdy;
  logic        w_busy;
  logic [3:0]  w_cnt;
  logic [1:0]  w_st;

  int n_vec;
  int n_err;
  logic [39:0] exp_q[$];

  handshake_rx dut (
    .clk(clk), .rst(rst), .req_i(req), .req_data_i(req_data), .ack_o(ack),
    .vld_o(vld), .data_o(data), .rdy_i(rdy), .busy_o(busy), .xfer_cnt_o(cnt),
    .fsm_state_o(st)
  );

  handshake_rx #(.DATA_W(40), .SYNC_STAGES(3), .CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .req_i(w_req), .req_data_i(w_data_in), .ack_o(w_ack),
    .vld_o(w_vld), .data_o(w_data), .rdy_i(w_rdy), .busy_o(w_busy), .xfer_cnt_o(w_cnt),
    .fsm_state_o(w_st)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    w_req = 1'b0;
    tick_n(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %0b exp 0", ack); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %0b exp 0", vld); end
    n_vec++; if (data !== 40'h0) begin n_err++; $display("FAIL rst_data: got %0h exp 0", data); end
    n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d exp 0", cnt); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    n_vec++; if (st !== 2'b00) begin n_err++; $display("FAIL rst_state: got %0b exp 00", st); end
    // reach ACK with a held word, then reset between edges with req still high
    rdy = 1'b0;
    req_data = 40'hAB_CDEF_0123;
    req = 1'b1;
    tick_n(3);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL pre_rst_ack: got %0b exp 1", ack); end
    rst = 1'b1;
    #1;
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL async_ack: got %0b exp 0", ack); end
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL async_vld: got %0b exp 0", vld); end
    n_vec++; if (data !== 40'h0) begin n_err++; $display("FAIL async_data: got %0h exp 0", data); end
    n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL async_cnt: got %0d exp 0", cnt); end
    tick();
    rst = 1'b0;
    tick_n(2);
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL recap_early: got %0b exp 0", vld); end
    tick();
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL recap_vld: got %0b exp 1", vld); end
    n_vec++; if (data !== 40'hAB_CDEF_0123) begin n_err++; $display("FAIL recap_data: got %0h exp abcdef0123", data); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL recap_cnt: got %0d exp 1", cnt); end
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL recap_ack: got %0b exp 1", ack); end
    req = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    rdy = 1'b1;
    req_data = 40'h12_3456_789A;
    req = 1'b1;
    tick_n(2);
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL basic_e2_vld: got %0b exp 0", vld); end
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL basic_e2_ack: got %0b exp 0", ack); end
    tick();
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL basic_e3_vld: got %0b exp 1", vld); end
    n_vec++; if (data !== 40'h12_3456_789A) begin n_err++; $display("FAIL basic_data: got %0h exp 123456789a", data); end
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_e3_ack: got %0b exp 1", ack); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL basic_cnt: got %0d exp 1", cnt); end
    n_vec++; if (st !== 2'b01) begin n_err++; $display("FAIL basic_state: got %0b exp 01", st); end
    tick();
    n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL basic_drain_vld: got %0b exp 0", vld); end
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_hold_ack: got %0b exp 1", ack); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0b exp 1", busy); end
    req = 1'b0;
    tick_n(2);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL basic_fall_e2: got %0b exp 1", ack); end
    tick();
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL basic_fall_e3: got %0b exp 0", ack); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy: got %0b exp 0", busy); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL basic_no_dup: got %0d exp 1", cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 1'b0;
    req_data = 40'hAA_0000_0001;
    req = 1'b1;
    tick_n(3);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL bp_a_ack: got %0b exp 1", ack); end
    req = 1'b0;
    tick_n(3);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL bp_a_fall: got %0b exp 0", ack); end
    req_data = 40'hBB_0000_0002;
    req = 1'b1;
    tick_n(6);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL bp_stall_ack: got %0b exp 0", ack); end
    n_vec++; if (data !== 40'hAA_0000_0001) begin n_err++; $display("FAIL bp_hold_data: got %0h exp aa00000001", data); end
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_hold_vld: got %0b exp 1", vld); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL bp_stall_cnt: got %0d exp 1", cnt); end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_vec++; if (vld !== 1'b1) begin n_err++; $display("FAIL bp_b_vld: got %0b exp 1", vld); end
    n_vec++; if (data !== 40'hBB_0000_0002) begin n_err++; $display("FAIL bp_b_data: got %0h exp bb00000002", data); end
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL bp_b_ack: got %0b exp 1", ack); end
    n_vec++; if (cnt !== 16'd2) begin n_err++; $display("FAIL bp_b_cnt: got %0d exp 2", cnt); end
    tick();
    n_vec++; if (data !== 40'hBB_0000_0002) begin n_err++; $display("FAIL bp_b_held: got %0h exp bb00000002", data); end
    req = 1'b0;
    tick_n(3);
    rdy = 1'b1;
    tick();
  endtask

  // Bench-side 4-phase sender against a randomly stalling consumer.
  task automatic test_stream();
    int  n_words;
    bit  snd_done;
    n_words = 24;
    snd_done = 1'b0;
    do_reset();
    fork
      begin
        for (int w = 0; w < n_words; w++) begin
          int to;
          req_data = {8'(w), 32'($urandom)};
          exp_q.push_back(req_data);
          req = 1'b1;
          to = 0;
          while (ack !== 1'b1 && to < 300) begin tick(); to++; end
          n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL stream_ack_rise: got %0b exp 1 word %0d", ack, w); end
          req = 1'b0;
          to = 0;
          while (ack !== 1'b0 && to < 300) begin tick(); to++; end
          n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL stream_ack_fall: got %0b exp 0 word %0d", ack, w); end
        end
        snd_done = 1'b1;
      end
      begin
        int guard;
        logic [39:0] exp_w;
        guard = 0;
        while (!(snd_done && exp_q.size() == 0) && guard < 6000) begin
          rdy = 1'($urandom_range(0, 1));
          if (vld && rdy) begin
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++; $display("FAIL stream_extra: got %0h exp none", data);
            end else begin
              exp_w = exp_q.pop_front();
              if (data !== exp_w) begin n_err++; $display("FAIL stream_data: got %0h exp %0h", data, exp_w); end
            end
          end
          tick();
          guard++;
        end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_lost: got %0d left exp 0", exp_q.size()); end
      end
    join
    n_vec++; if (cnt !== 16'(n_words)) begin n_err++; $display("FAIL stream_cnt: got %0d exp %0d", cnt, n_words); end
    rdy = 1'b1;
    exp_q.delete();
  endtask

  task automatic w_xfer(input logic [39:0] d);
    int to;
    w_data_in = d;
    w_req = 1'b1;
    to = 0;
    while (w_ack !== 1'b1 && to < 50) begin tick(); to++; end
    n_vec++; if (w_ack !== 1'b1) begin n_err++; $display("FAIL wrap_ack_rise: got %0b exp 1", w_ack); end
    w_req = 1'b0;
    to = 0;
    while (w_ack !== 1'b0 && to < 50) begin tick(); to++; end
    n_vec++; if (w_ack !== 1'b0) begin n_err++; $display("FAIL wrap_ack_fall: got %0b exp 0", w_ack); end
  endtask

  task automatic test_wrap_sync3();
    do_reset();
    w_rdy = 1'b1;
    w_data_in = 40'h33_0000_0000;
    w_req = 1'b1;
    tick_n(3);
    n_vec++; if (w_vld !== 1'b0) begin n_err++; $display("FAIL sync3_e3_vld: got %0b exp 0", w_vld); end
    tick();
    n_vec++; if (w_vld !== 1'b1) begin n_err++; $display("FAIL sync3_e4_vld: got %0b exp 1", w_vld); end
    n_vec++; if (w_data !== 40'h33_0000_0000) begin n_err++; $display("FAIL sync3_data: got %0h exp 3300000000", w_data); end
    w_req = 1'b0;
    tick_n(3);
    n_vec++; if (w_ack !== 1'b1) begin n_err++; $display("FAIL sync3_fall_e3: got %0b exp 1", w_ack); end
    tick();
    n_vec++; if (w_ack !== 1'b0) begin n_err++; $display("FAIL sync3_fall_e4: got %0b exp 0", w_ack); end
    for (int k = 2; k <= 15; k++) w_xfer(40'(k));
    n_vec++; if (w_cnt !== 4'd15) begin n_err++; $display("FAIL wrap_15: got %0d exp 15", w_cnt); end
    w_xfer(40'd16);
    n_vec++; if (w_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_16: got %0d exp 0", w_cnt); end
    w_xfer(40'd17);
    n_vec++; if (w_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_17: got %0d exp 1", w_cnt); end
    n_vec++; if (w_data !== 40'd17) begin n_err++; $display("FAIL wrap_last_data: got %0h exp 11", w_data); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    req = 1'b0;
    req_data = '0;
    rdy = 1'b1;
    w_req = 1'b0;
    w_data_in = '0;
    w_rdy = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_wrap_sync3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
